// File: rtl/kbd_event_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// kbd_event_sched: held-key tracking, auto-repeat timers and a merged event FIFO
// Revision 1.0
// ----------------------------------------------------------------------------
module kbd_event_sched #(
  parameter int                    NKEYS         = 4,
  parameter logic [0:NKEYS-1][8:0] KEY_CODES     = {9'h175, 9'h172, 9'h16B, 9'h174},
  parameter int                    REPEAT_DELAY  = 25000000,
  parameter int                    REPEAT_PERIOD = 5000000,
  parameter int                    FIFO_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic [8:0]       key_Pressed,
  input  logic             make,
  input  logic             brakk,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic [8:0]       evt_code,
  output logic [1:0]       evt_type,
  output logic [NKEYS-1:0] held,
  output logic             overflow,
  input  logic             ovf_clr
);

  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(TMAX);
  localparam int KW   = (NKEYS > 1) ? $clog2(NKEYS) : 1;
  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = $clog2(FIFO_DEPTH + 1);

  localparam logic [TW-1:0] C_DELAY     = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] C_PERIOD    = TW'(REPEAT_PERIOD - 1);
  localparam logic [CW-1:0] C_FULL      = CW'(FIFO_DEPTH);
  localparam logic [AW-1:0] C_LAST_SLOT = AW'(FIFO_DEPTH - 1);
  localparam logic [1:0]    C_T_MAKE    = 2'b01;
  localparam logic [1:0]    C_T_BREAK   = 2'b10;
  localparam logic [1:0]    C_T_REP     = 2'b11;

  logic [NKEYS-1:0] r_held;
  logic [NKEYS-1:0] r_pending;
  logic [TW-1:0]    r_timer [NKEYS];
  logic [KW-1:0]    r_last_grant;
  logic [10:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [10:0]      r_last_out;
  logic             r_overflow;

  logic [NKEYS-1:0] w_hit;
  logic [NKEYS-1:0] w_mk;
  logic [NKEYS-1:0] w_brk;
  logic [NKEYS-1:0] w_grant;
  logic             w_strobe;
  logic             w_pop;
  logic             w_can_push;
  logic             w_push;
  logic             w_drop;
  logic             w_hi_any;
  logic             w_lo_any;
  logic [KW-1:0]    w_hi_idx;
  logic [KW-1:0]    w_lo_idx;
  logic [KW-1:0]    w_gidx;
  logic             w_gvalid;
  logic [10:0]      w_din;

  // brakk outranks make; make on a held key and break on a released key are no-ops
  for (genvar i = 0; i < NKEYS; i++) begin : g_key
    assign w_hit[i] = (key_Pressed == KEY_CODES[i]);
    assign w_brk[i] = brakk & w_hit[i] & r_held[i];
    assign w_mk[i]  = make & ~brakk & w_hit[i] & ~r_held[i];
  end

  assign w_strobe   = (|w_mk) | (|w_brk);
  assign evt_valid  = (r_count != '0);
  assign w_pop      = evt_valid & evt_ready;
  assign w_can_push = (r_count != C_FULL) | w_pop;

  // Round-robin: lowest pending index above the last grant, else lowest pending overall
  always_comb begin
    w_hi_any = 1'b0;
    w_lo_any = 1'b0;
    w_hi_idx = '0;
    w_lo_idx = '0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_lo_any = 1'b1;
        w_lo_idx = KW'(i);
        if (KW'(i) > r_last_grant) begin
          w_hi_any = 1'b1;
          w_hi_idx = KW'(i);
        end
      end
    end
  end

  assign w_gidx   = w_hi_any ? w_hi_idx : w_lo_idx;
  assign w_gvalid = (w_hi_any | w_lo_any) & ~w_strobe & w_can_push;

  always_comb begin
    w_grant = '0;
    for (int i = 0; i < NKEYS; i++) begin
      w_grant[i] = w_gvalid & (w_gidx == KW'(i));
    end
  end

  assign w_push = (w_strobe & w_can_push) | w_gvalid;
  assign w_drop = w_strobe & ~w_can_push;
  assign w_din  = w_strobe ? {key_Pressed, (brakk ? C_T_BREAK : C_T_MAKE)}
                           : {KEY_CODES[w_gidx], C_T_REP};

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_held    <= '0;
      r_pending <= '0;
      for (int i = 0; i < NKEYS; i++) begin
        r_timer[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NKEYS; i++) begin
        if (w_brk[i]) begin
          r_held[i]    <= 1'b0;
          r_pending[i] <= 1'b0;
          r_timer[i]   <= '0;
        end else if (w_mk[i]) begin
          r_held[i]  <= 1'b1;
          r_timer[i] <= C_DELAY;
        end else if (r_held[i]) begin
          // An expiry re-arms pending even if a grant clears it this same cycle
          if (r_timer[i] == '0) begin
            r_timer[i]   <= C_PERIOD;
            r_pending[i] <= 1'b1;
          end else begin
            r_timer[i] <= r_timer[i] - TW'(1);
            if (w_grant[i]) begin
              r_pending[i] <= 1'b0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_last_out   <= '0;
      r_last_grant <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_din;
        r_wr_ptr        <= (r_wr_ptr == C_LAST_SLOT) ? '0 : r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr   <= (r_rd_ptr == C_LAST_SLOT) ? '0 : r_rd_ptr + AW'(1);
        r_last_out <= r_mem[r_rd_ptr];
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_gvalid) begin
        r_last_grant <= w_gidx;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Once drained, the outputs keep showing the most recently consumed event
  assign {evt_code, evt_type} = evt_valid ? r_mem[r_rd_ptr] : r_last_out;
  assign held                 = r_held;
  assign overflow             = r_overflow;

endmodule
`default_nettype wire
